dispatch_unit: RTL and testbench

Parametrised dispatch stage of the Tomasulo core, placed between the decoder (ID) and the ROB, reservation station (RS) and load/store buffer (LSB). It buffers one decoded instruction per cycle and resolves source operands from the regfile, ROB and N result-broadcast (CDB) channels. It allocates the ROB tail, renames the destination register, and routes the instruction to RS or LSB with full/stall handshaking and flush support. It succeeds the single-cycle combinational dispatcher; the pipelined holding register and multi-channel snooping are new.

---
 rtl/dispatch_unit_pkg.sv | 19 +
 rtl/dispatch_unit_operand.sv | 61 ++++++
 rtl/dispatch_unit.sv | 215 +++++++++++++++++++++
 tb/tb_dispatch_unit.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_unit_pkg.sv
// Shared definitions for the dispatch stage: default widths and internal opcode encodings.
package dispatch_unit_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_ROB_W = 4;
    localparam int DEF_OP_W  = 6;
    localparam int DEF_N_CDB = 2;

    typedef enum logic [DEF_OP_W-1:0] {
        OP_NOP = 6'd0,
        OP_ADD = 6'd1,
        OP_SUB = 6'd2,
        OP_AND = 6'd3,
        OP_OR  = 6'd4,
        OP_LW  = 6'd8,
        OP_SW  = 6'd9
    } op_e;

endpackage

// File: rtl/dispatch_unit_operand.sv
// One source operand: priority chain (zero, internal bypass, regfile, ROB, CDB) plus N-channel CDB match.
module operand_resolve
    import dispatch_unit_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int ROB_W = DEF_ROB_W,
    parameter int N_CDB = DEF_N_CDB
) (
    input  logic                   rs_zero,
    input  logic                   byp_hit,
    input  logic [ROB_W-1:0]       byp_tag,
    input  logic                   busy,
    input  logic [ROB_W-1:0]       tag,
    input  logic [XLEN-1:0]        val,
    input  logic                   src_rdy,
    input  logic [XLEN-1:0]        src_val,
    input  logic [N_CDB-1:0]       cdb_valid,
    input  logic [N_CDB*ROB_W-1:0] cdb_tag,
    input  logic [N_CDB*XLEN-1:0]  cdb_val,
    output logic                   op_rdy,
    output logic [XLEN-1:0]        op_val,
    output logic [ROB_W-1:0]       op_tag
);

    logic            cdb_hit;
    logic [XLEN-1:0] cdb_sel;

    // Scan downwards so the lowest matching channel is the last one written.
    always_comb begin
        cdb_hit = 1'b0;
        cdb_sel = '0;
        for (int i = N_CDB - 1; i >= 0; i--) begin
            if (cdb_valid[i] && (cdb_tag[i*ROB_W +: ROB_W] == tag)) begin
                cdb_hit = 1'b1;
                cdb_sel = cdb_val[i*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        op_rdy = 1'b1;
        op_val = '0;
        op_tag = '0;
        if (!rs_zero) begin
            if (byp_hit) begin
                op_rdy = 1'b0;
                op_tag = byp_tag;
            end else if (!busy) begin
                op_val = val;
            end else if (src_rdy) begin
                op_val = src_val;
            end else if (cdb_hit) begin
                op_val = cdb_sel;
            end else begin
                op_rdy = 1'b0;
                op_tag = tag;
            end
        end
    end

endmodule

// File: rtl/dispatch_unit.sv
// Dispatch stage: one-entry holding register between decode and ROB/RS/LSB, with
// operand resolution on accept and CDB snooping while the entry waits to issue.
module dispatch_unit
    import dispatch_unit_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int ROB_W = DEF_ROB_W,
    parameter int OP_W  = DEF_OP_W,
    parameter int N_CDB = DEF_N_CDB
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rdy,
    input  logic                   flush,
    input  logic                   id_valid,
    output logic                   id_ready,
    input  logic [OP_W-1:0]        id_op,
    input  logic [XLEN-1:0]        id_pc,
    input  logic [XLEN-1:0]        id_imm,
    input  logic                   id_is_ls,
    input  logic                   id_wb,
    input  logic [4:0]             id_rd,
    input  logic [4:0]             id_rs1,
    input  logic [4:0]             id_rs2,
    input  logic                   rf_rs1_busy,
    input  logic [ROB_W-1:0]       rf_rs1_tag,
    input  logic [XLEN-1:0]        rf_rs1_val,
    input  logic                   rf_rs2_busy,
    input  logic [ROB_W-1:0]       rf_rs2_tag,
    input  logic [XLEN-1:0]        rf_rs2_val,
    input  logic                   rob_rs1_rdy,
    input  logic [XLEN-1:0]        rob_rs1_val,
    input  logic                   rob_rs2_rdy,
    input  logic [XLEN-1:0]        rob_rs2_val,
    input  logic [N_CDB-1:0]       cdb_valid,
    input  logic [N_CDB*ROB_W-1:0] cdb_tag,
    input  logic [N_CDB*XLEN-1:0]  cdb_val,
    input  logic                   rob_full,
    input  logic [ROB_W-1:0]       rob_tail,
    input  logic                   rs_full,
    input  logic                   lsb_full,
    output logic                   rob_alloc,
    output logic [OP_W-1:0]        rob_op,
    output logic [4:0]             rob_rd,
    output logic [XLEN-1:0]        rob_pc,
    output logic                   rn_we,
    output logic [4:0]             rn_rd,
    output logic [ROB_W-1:0]       rn_tag,
    output logic                   rs_valid,
    output logic                   lsb_valid,
    output logic [OP_W-1:0]        iss_op,
    output logic [XLEN-1:0]        iss_pc,
    output logic [XLEN-1:0]        iss_imm,
    output logic [ROB_W-1:0]       iss_tag,
    output logic                   iss_j_rdy,
    output logic [XLEN-1:0]        iss_vj,
    output logic [ROB_W-1:0]       iss_qj,
    output logic                   iss_k_rdy,
    output logic [XLEN-1:0]        iss_vk,
    output logic [ROB_W-1:0]       iss_qk
);

    logic             h_valid_q, h_valid_d;
    logic [OP_W-1:0]  h_op_q,    h_op_d;
    logic [XLEN-1:0]  h_pc_q,    h_pc_d;
    logic [XLEN-1:0]  h_imm_q,   h_imm_d;
    logic             h_is_ls_q, h_is_ls_d;
    logic             h_wb_q,    h_wb_d;
    logic [4:0]       h_rd_q,    h_rd_d;
    logic             h_j_rdy_q, h_j_rdy_d;
    logic [XLEN-1:0]  h_vj_q,    h_vj_d;
    logic [ROB_W-1:0] h_qj_q,    h_qj_d;
    logic             h_k_rdy_q, h_k_rdy_d;
    logic [XLEN-1:0]  h_vk_q,    h_vk_d;
    logic [ROB_W-1:0] h_qk_q,    h_qk_d;

    logic             can_issue, accept;
    logic             acc_j_rdy, acc_k_rdy, held_j_rdy, held_k_rdy;
    logic [XLEN-1:0]  acc_j_val, acc_k_val, held_j_val, held_k_val;
    logic [ROB_W-1:0] acc_j_tag, acc_k_tag, held_j_tag, held_k_tag;

    assign can_issue = rdy & ~flush & h_valid_q & ~rob_full & (h_is_ls_q ? ~lsb_full : ~rs_full);
    assign id_ready  = rst_n & rdy & ~flush & (~h_valid_q | can_issue);
    assign accept    = id_valid & id_ready;

    // Accept-time resolution; the bypass covers a producer issuing from H this same cycle.
    operand_resolve #(.XLEN(XLEN), .ROB_W(ROB_W), .N_CDB(N_CDB)) u_acc_j (
        .rs_zero(id_rs1 == 5'd0), .byp_hit(can_issue & h_wb_q & (h_rd_q == id_rs1)),
        .byp_tag(rob_tail), .busy(rf_rs1_busy), .tag(rf_rs1_tag), .val(rf_rs1_val),
        .src_rdy(rob_rs1_rdy), .src_val(rob_rs1_val),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .op_rdy(acc_j_rdy), .op_val(acc_j_val), .op_tag(acc_j_tag)
    );

    operand_resolve #(.XLEN(XLEN), .ROB_W(ROB_W), .N_CDB(N_CDB)) u_acc_k (
        .rs_zero(id_rs2 == 5'd0), .byp_hit(can_issue & h_wb_q & (h_rd_q == id_rs2)),
        .byp_tag(rob_tail), .busy(rf_rs2_busy), .tag(rf_rs2_tag), .val(rf_rs2_val),
        .src_rdy(rob_rs2_rdy), .src_val(rob_rs2_val),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .op_rdy(acc_k_rdy), .op_val(acc_k_val), .op_tag(acc_k_tag)
    );

    // Held operands: a ready operand passes through, a pending one picks up a matching broadcast.
    operand_resolve #(.XLEN(XLEN), .ROB_W(ROB_W), .N_CDB(N_CDB)) u_held_j (
        .rs_zero(1'b0), .byp_hit(1'b0), .byp_tag('0),
        .busy(~h_j_rdy_q), .tag(h_qj_q), .val(h_vj_q), .src_rdy(1'b0), .src_val('0),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .op_rdy(held_j_rdy), .op_val(held_j_val), .op_tag(held_j_tag)
    );

    operand_resolve #(.XLEN(XLEN), .ROB_W(ROB_W), .N_CDB(N_CDB)) u_held_k (
        .rs_zero(1'b0), .byp_hit(1'b0), .byp_tag('0),
        .busy(~h_k_rdy_q), .tag(h_qk_q), .val(h_vk_q), .src_rdy(1'b0), .src_val('0),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .op_rdy(held_k_rdy), .op_val(held_k_val), .op_tag(held_k_tag)
    );

    always_comb begin
        h_valid_d = h_valid_q;
        h_op_d    = h_op_q;
        h_pc_d    = h_pc_q;
        h_imm_d   = h_imm_q;
        h_is_ls_d = h_is_ls_q;
        h_wb_d    = h_wb_q;
        h_rd_d    = h_rd_q;
        h_j_rdy_d = h_j_rdy_q;
        h_vj_d    = h_vj_q;
        h_qj_d    = h_qj_q;
        h_k_rdy_d = h_k_rdy_q;
        h_vk_d    = h_vk_q;
        h_qk_d    = h_qk_q;
        if (rdy) begin
            h_j_rdy_d = held_j_rdy;
            h_vj_d    = held_j_val;
            h_qj_d    = held_j_tag;
            h_k_rdy_d = held_k_rdy;
            h_vk_d    = held_k_val;
            h_qk_d    = held_k_tag;
            if (flush) begin
                h_valid_d = 1'b0;
            end else if (accept) begin
                h_valid_d = 1'b1;
                h_op_d    = id_op;
                h_pc_d    = id_pc;
                h_imm_d   = id_imm;
                h_is_ls_d = id_is_ls;
                h_wb_d    = id_wb;
                h_rd_d    = id_rd;
                h_j_rdy_d = acc_j_rdy;
                h_vj_d    = acc_j_val;
                h_qj_d    = acc_j_tag;
                h_k_rdy_d = acc_k_rdy;
                h_vk_d    = acc_k_val;
                h_qk_d    = acc_k_tag;
            end else if (can_issue) begin
                h_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_valid_q <= 1'b0;
            h_op_q    <= '0;
            h_pc_q    <= '0;
            h_imm_q   <= '0;
            h_is_ls_q <= 1'b0;
            h_wb_q    <= 1'b0;
            h_rd_q    <= '0;
            h_j_rdy_q <= 1'b0;
            h_vj_q    <= '0;
            h_qj_q    <= '0;
            h_k_rdy_q <= 1'b0;
            h_vk_q    <= '0;
            h_qk_q    <= '0;
        end else begin
            h_valid_q <= h_valid_d;
            h_op_q    <= h_op_d;
            h_pc_q    <= h_pc_d;
            h_imm_q   <= h_imm_d;
            h_is_ls_q <= h_is_ls_d;
            h_wb_q    <= h_wb_d;
            h_rd_q    <= h_rd_d;
            h_j_rdy_q <= h_j_rdy_d;
            h_vj_q    <= h_vj_d;
            h_qj_q    <= h_qj_d;
            h_k_rdy_q <= h_k_rdy_d;
            h_vk_q    <= h_vk_d;
            h_qk_q    <= h_qk_d;
        end
    end

    assign rob_alloc = can_issue;
    assign rs_valid  = can_issue & ~h_is_ls_q;
    assign lsb_valid = can_issue & h_is_ls_q;
    assign rob_op    = h_op_q;
    assign rob_rd    = h_rd_q;
    assign rob_pc    = h_pc_q;
    assign rn_we     = can_issue & h_wb_q & (h_rd_q != 5'd0);
    assign rn_rd     = h_rd_q;
    assign rn_tag    = can_issue ? rob_tail : '0;

    // Operand outputs carry the issue-cycle CDB bypass; masked while H is empty.
    assign iss_op    = h_op_q;
    assign iss_pc    = h_pc_q;
    assign iss_imm   = h_imm_q;
    assign iss_tag   = can_issue ? rob_tail : '0;
    assign iss_j_rdy = h_valid_q & held_j_rdy;
    assign iss_vj    = h_valid_q ? held_j_val : '0;
    assign iss_qj    = h_valid_q ? held_j_tag : '0;
    assign iss_k_rdy = h_valid_q & held_k_rdy;
    assign iss_vk    = h_valid_q ? held_k_val : '0;
    assign iss_qk    = h_valid_q ? held_k_tag : '0;

endmodule

// File: tb/tb_dispatch_unit.sv
// Scoreboard bench for dispatch_unit: directed instructions push expected issue records,
// a negedge monitor pops and compares whenever rob_alloc is presented.
module tb_dispatch_unit;
    import dispatch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, rdy, flush;
    logic        id_valid, id_ready;
    logic [5:0]  id_op;
    logic [31:0] id_pc, id_imm;
    logic        id_is_ls, id_wb;
    logic [4:0]  id_rd, id_rs1, id_rs2;
    logic        rf_rs1_busy, rf_rs2_busy;
    logic [3:0]  rf_rs1_tag, rf_rs2_tag;
    logic [31:0] rf_rs1_val, rf_rs2_val;
    logic        rob_rs1_rdy, rob_rs2_rdy;
    logic [31:0] rob_rs1_val, rob_rs2_val;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_tag;
    logic [63:0] cdb_val;
    logic        rob_full, rs_full, lsb_full;
    logic [3:0]  rob_tail;
    logic        rob_alloc, rn_we, rs_valid, lsb_valid;
    logic [5:0]  rob_op, iss_op;
    logic [4:0]  rob_rd, rn_rd;
    logic [31:0] rob_pc, iss_pc, iss_imm, iss_vj, iss_vk;
    logic [3:0]  rn_tag, iss_tag, iss_qj, iss_qk;
    logic        iss_j_rdy, iss_k_rdy;

    typedef struct {
        logic        is_ls;
        logic [5:0]  op;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [3:0]  tag;
        logic        j_rdy;
        logic [31:0] vj;
        logic [3:0]  qj;
        logic        k_rdy;
        logic [31:0] vk;
        logic [3:0]  qk;
        logic        rn_we;
        logic [4:0]  rn_rd;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    dispatch_unit dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_op(id_op), .id_pc(id_pc), .id_imm(id_imm),
        .id_is_ls(id_is_ls), .id_wb(id_wb), .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .rf_rs1_busy(rf_rs1_busy), .rf_rs1_tag(rf_rs1_tag), .rf_rs1_val(rf_rs1_val),
        .rf_rs2_busy(rf_rs2_busy), .rf_rs2_tag(rf_rs2_tag), .rf_rs2_val(rf_rs2_val),
        .rob_rs1_rdy(rob_rs1_rdy), .rob_rs1_val(rob_rs1_val),
        .rob_rs2_rdy(rob_rs2_rdy), .rob_rs2_val(rob_rs2_val),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .rob_full(rob_full), .rob_tail(rob_tail), .rs_full(rs_full), .lsb_full(lsb_full),
        .rob_alloc(rob_alloc), .rob_op(rob_op), .rob_rd(rob_rd), .rob_pc(rob_pc),
        .rn_we(rn_we), .rn_rd(rn_rd), .rn_tag(rn_tag),
        .rs_valid(rs_valid), .lsb_valid(lsb_valid),
        .iss_op(iss_op), .iss_pc(iss_pc), .iss_imm(iss_imm), .iss_tag(iss_tag),
        .iss_j_rdy(iss_j_rdy), .iss_vj(iss_vj), .iss_qj(iss_qj),
        .iss_k_rdy(iss_k_rdy), .iss_vk(iss_vk), .iss_qk(iss_qk)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] imm,
                                 input logic is_ls, input logic wb, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2);
        id_valid = 1'b1;
        id_op    = op;
        id_pc    = pc;
        id_imm   = imm;
        id_is_ls = is_ls;
        id_wb    = wb;
        id_rd    = rd;
        id_rs1   = rs1;
        id_rs2   = rs2;
    endtask

    task automatic clearId();
        id_valid = 1'b0; id_op = '0; id_pc = '0; id_imm = '0; id_is_ls = 1'b0; id_wb = 1'b0;
        id_rd = '0; id_rs1 = '0; id_rs2 = '0;
        rf_rs1_busy = 1'b0; rf_rs1_tag = '0; rf_rs1_val = '0;
        rf_rs2_busy = 1'b0; rf_rs2_tag = '0; rf_rs2_val = '0;
        rob_rs1_rdy = 1'b0; rob_rs1_val = '0; rob_rs2_rdy = 1'b0; rob_rs2_val = '0;
    endtask

    task automatic cdbIdle();
        cdb_valid = '0; cdb_tag = '0; cdb_val = '0;
    endtask

    task automatic pushExp(input logic is_ls, input logic [5:0] op, input logic [31:0] pc,
                           input logic [31:0] imm, input logic [3:0] tag,
                           input logic j_rdy, input logic [31:0] vj, input logic [3:0] qj,
                           input logic k_rdy, input logic [31:0] vk, input logic [3:0] qk,
                           input logic rnwe, input logic [4:0] rnrd);
        exp_t e;
        e.is_ls = is_ls; e.op = op; e.pc = pc; e.imm = imm; e.tag = tag;
        e.j_rdy = j_rdy; e.vj = vj; e.qj = qj; e.k_rdy = k_rdy; e.vk = vk; e.qk = qk;
        e.rn_we = rnwe; e.rn_rd = rnrd;
        exp_q.push_back(e);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every issue presented by the DUT must match the oldest expected record.
    always @(negedge clk) begin
        if (rst_n && rob_alloc) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_issue", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("iss_rs_valid", {31'd0, rs_valid}, {31'd0, ~e.is_ls});
                checkOutput("iss_lsb_valid", {31'd0, lsb_valid}, {31'd0, e.is_ls});
                checkOutput("iss_op", {26'd0, iss_op}, {26'd0, e.op});
                checkOutput("iss_pc", iss_pc, e.pc);
                checkOutput("rob_pc", rob_pc, e.pc);
                checkOutput("iss_imm", iss_imm, e.imm);
                checkOutput("iss_tag", {28'd0, iss_tag}, {28'd0, e.tag});
                checkOutput("iss_j_rdy", {31'd0, iss_j_rdy}, {31'd0, e.j_rdy});
                checkOutput("iss_vj", iss_vj, e.vj);
                checkOutput("iss_qj", {28'd0, iss_qj}, {28'd0, e.qj});
                checkOutput("iss_k_rdy", {31'd0, iss_k_rdy}, {31'd0, e.k_rdy});
                checkOutput("iss_vk", iss_vk, e.vk);
                checkOutput("iss_qk", {28'd0, iss_qk}, {28'd0, e.qk});
                checkOutput("rn_we", {31'd0, rn_we}, {31'd0, e.rn_we});
                checkOutput("rn_rd", {27'd0, rn_rd}, {27'd0, e.rn_rd});
                if (e.rn_we)
                    checkOutput("rn_tag", {28'd0, rn_tag}, {28'd0, e.tag});
            end
        end
    end

    initial begin
        rst_n = 1'b0; rdy = 1'b1; flush = 1'b0;
        rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0; rob_tail = '0;
        clearId();
        cdbIdle();
        nextCycle();
        nextCycle();
        @(negedge clk);
        checkOutput("rst_id_ready", {31'd0, id_ready}, 32'd0);
        checkOutput("rst_rob_alloc", {31'd0, rob_alloc}, 32'd0);
        nextCycle();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_id_ready", {31'd0, id_ready}, 32'd1);

        // Reset while an instruction is held by a full RS.
        nextCycle();
        rs_full = 1'b1;
        applyStimulus(OP_ADD, 32'h50, 32'h0, 1'b0, 1'b1, 5'd1, 5'd0, 5'd0);
        nextCycle();
        clearId();
        @(negedge clk);
        checkOutput("hold_no_alloc", {31'd0, rob_alloc}, 32'd0);
        checkOutput("hold_pc", iss_pc, 32'h50);
        checkOutput("hold_id_ready", {31'd0, id_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_iss_pc", iss_pc, 32'd0);
        checkOutput("midrst_rob_alloc", {31'd0, rob_alloc}, 32'd0);
        checkOutput("midrst_rs_valid", {31'd0, rs_valid}, 32'd0);
        checkOutput("midrst_rn_we", {31'd0, rn_we}, 32'd0);
        nextCycle();
        rs_full = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midrst_after_id_ready", {31'd0, id_ready}, 32'd1);
        checkOutput("midrst_after_alloc", {31'd0, rob_alloc}, 32'd0);

        // Back-to-back dependent adds: second sees pending tag 3 via internal bypass.
        nextCycle();
        rob_tail = 4'd3;
        applyStimulus(OP_ADD, 32'h100, 32'h0, 1'b0, 1'b1, 5'd5, 5'd1, 5'd2);
        rf_rs1_val = 32'h10; rf_rs2_val = 32'h20;
        pushExp(1'b0, OP_ADD, 32'h100, 32'h0, 4'd3, 1'b1, 32'h10, 4'd0, 1'b1, 32'h20, 4'd0, 1'b1, 5'd5);
        nextCycle();
        applyStimulus(OP_ADD, 32'h104, 32'h0, 1'b0, 1'b1, 5'd6, 5'd5, 5'd0);
        rf_rs1_val = 32'hDEAD; rf_rs2_val = 32'h0;
        pushExp(1'b0, OP_ADD, 32'h104, 32'h0, 4'd4, 1'b0, 32'h0, 4'd3, 1'b1, 32'h0, 4'd0, 1'b1, 5'd6);
        @(negedge clk);
        checkOutput("b2b_id_ready", {31'd0, id_ready}, 32'd1);
        nextCycle();
        clearId();
        rob_tail = 4'd4;
        @(negedge clk);
        checkOutput("b2b_second_alloc", {31'd0, rob_alloc}, 32'd1);
        nextCycle();
        @(negedge clk);
        checkOutput("b2b_drained", {31'd0, rob_alloc}, 32'd0);

        // Pending tag 7 snooped from CDB channel 1 while RS is full.
        nextCycle();
        rob_tail = 4'd5;
        rs_full = 1'b1;
        applyStimulus(OP_SUB, 32'h200, 32'h0, 1'b0, 1'b1, 5'd7, 5'd8, 5'd0);
        rf_rs1_busy = 1'b1; rf_rs1_tag = 4'd7; rf_rs1_val = 32'h999;
        pushExp(1'b0, OP_SUB, 32'h200, 32'h0, 4'd5, 1'b1, 32'h1234, 4'd0, 1'b1, 32'h0, 4'd0, 1'b1, 5'd7);
        nextCycle();
        clearId();
        @(negedge clk);
        checkOutput("snoop_stall1", {31'd0, rob_alloc}, 32'd0);
        checkOutput("snoop_pending", {31'd0, iss_j_rdy}, 32'd0);
        nextCycle();
        cdb_valid = 2'b10; cdb_tag = {4'd7, 4'd7}; cdb_val = {32'h1234, 32'hBAD};
        @(negedge clk);
        checkOutput("snoop_stall2", {31'd0, rob_alloc}, 32'd0);
        nextCycle();
        cdbIdle();
        @(negedge clk);
        checkOutput("snoop_stall3", {31'd0, rs_valid}, 32'd0);
        checkOutput("snoop_latched_vj", iss_vj, 32'h1234);
        nextCycle();
        rs_full = 1'b0;
        @(negedge clk);
        nextCycle();

        // Broadcast in the exact issue cycle; rd=0 gives no rename write.
        rob_tail = 4'd6;
        applyStimulus(OP_ADD, 32'h300, 32'h0, 1'b0, 1'b1, 5'd0, 5'd3, 5'd4);
        rf_rs1_busy = 1'b1; rf_rs1_tag = 4'd9;
        rf_rs2_busy = 1'b1; rf_rs2_tag = 4'd10;
        pushExp(1'b0, OP_ADD, 32'h300, 32'h0, 4'd6, 1'b1, 32'h9999, 4'd0, 1'b1, 32'h5555, 4'd0, 1'b0, 5'd0);
        nextCycle();
        clearId();
        cdb_valid = 2'b11; cdb_tag = {4'd9, 4'd10}; cdb_val = {32'h9999, 32'h5555};
        @(negedge clk);
        nextCycle();
        cdbIdle();

        // Load held by a full LSB while RS has room; rs1 from lowest CDB channel, rs2 from ROB.
        rob_tail = 4'd8;
        lsb_full = 1'b1;
        applyStimulus(OP_LW, 32'h400, 32'h10, 1'b1, 1'b1, 5'd10, 5'd11, 5'd6);
        rf_rs1_busy = 1'b1; rf_rs1_tag = 4'd11;
        rf_rs2_busy = 1'b1; rf_rs2_tag = 4'd2; rob_rs2_rdy = 1'b1; rob_rs2_val = 32'h77;
        cdb_valid = 2'b11; cdb_tag = {4'd11, 4'd11}; cdb_val = {32'h222, 32'h111};
        pushExp(1'b1, OP_LW, 32'h400, 32'h10, 4'd8, 1'b1, 32'h111, 4'd0, 1'b1, 32'h77, 4'd0, 1'b1, 5'd10);
        nextCycle();
        clearId();
        cdbIdle();
        @(negedge clk);
        checkOutput("lsb_full_no_alloc", {31'd0, rob_alloc}, 32'd0);
        checkOutput("lsb_full_no_rs", {31'd0, rs_valid}, 32'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("lsb_full_no_lsb", {31'd0, lsb_valid}, 32'd0);
        nextCycle();
        lsb_full = 1'b0;
        @(negedge clk);
        nextCycle();

        // Flush with an issuable entry: no strobes now, nothing left next cycle.
        rob_tail = 4'd1;
        applyStimulus(OP_ADD, 32'h500, 32'h0, 1'b0, 1'b1, 5'd12, 5'd0, 5'd0);
        nextCycle();
        applyStimulus(OP_SUB, 32'h504, 32'h0, 1'b0, 1'b1, 5'd13, 5'd0, 5'd0);
        flush = 1'b1;
        @(negedge clk);
        checkOutput("flush_alloc", {31'd0, rob_alloc}, 32'd0);
        checkOutput("flush_rs_valid", {31'd0, rs_valid}, 32'd0);
        checkOutput("flush_rn_we", {31'd0, rn_we}, 32'd0);
        checkOutput("flush_id_ready", {31'd0, id_ready}, 32'd0);
        nextCycle();
        flush = 1'b0;
        clearId();
        @(negedge clk);
        checkOutput("post_flush_alloc", {31'd0, rob_alloc}, 32'd0);
        checkOutput("post_flush_rn_we", {31'd0, rn_we}, 32'd0);
        checkOutput("post_flush_id_ready", {31'd0, id_ready}, 32'd1);
        nextCycle();

        // rdy=0 freezes H, so a broadcast during the freeze is not captured.
        rob_tail = 4'd2;
        applyStimulus(OP_ADD, 32'h600, 32'h0, 1'b0, 1'b1, 5'd14, 5'd15, 5'd0);
        rf_rs1_busy = 1'b1; rf_rs1_tag = 4'd13;
        pushExp(1'b0, OP_ADD, 32'h600, 32'h0, 4'd2, 1'b0, 32'h0, 4'd13, 1'b1, 32'h0, 4'd0, 1'b1, 5'd14);
        nextCycle();
        clearId();
        rdy = 1'b0;
        cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd13}; cdb_val = {32'h0, 32'hF00};
        @(negedge clk);
        checkOutput("freeze_alloc", {31'd0, rob_alloc}, 32'd0);
        checkOutput("freeze_id_ready", {31'd0, id_ready}, 32'd0);
        nextCycle();
        rdy = 1'b1;
        cdbIdle();
        @(negedge clk);
        nextCycle();
        nextCycle();

        checkOutput("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
